pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//   Receive-side counterpart of the motor PWM generator. Samples an external PWM
//   line and measures period and high time in m_clock cycles.
//   Publishes a coherent {period, high} pair once per PWM period and flags a
//   stalled line. Sits between motor feedback/servo input pins and control logic.
// PARAMETERS
//   CNT_W    31     width of all cycle counters and count outputs
//   TIMEOUT  70000  cycles without a rising edge before timeout (2x nominal 35000 period)
//                   legal range: 2 <= TIMEOUT <= 2**CNT_W-1
// PORTS
//   m_clock       in   1      system clock, all logic on rising edge
//   p_reset       in   1      reset, synchronous, active-high
//   enable        in   1      1 = measure; 0 = idle (synchronous)
//   pwm_in        in   1      asynchronous PWM line
//   period_count  out  CNT_W  cycles between last two rising edges
//   high_count    out  CNT_W  high cycles within that period
//   valid         out  1      one-cycle strobe: new pair on period_count/high_count
//   timeout       out  1      level: no rising edge for TIMEOUT cycles
// BEHAVIOUR
//   Reset: state=IDLE; period_count=0, high_count=0, valid=0, timeout=0; sync flops=0.
//   Input: s1<=pwm_in, s2<=s1, s3<=s2. rise = s2&~s3, fall = ~s2&s3.
//   Latency: edge E1 first samples pwm_in=1. Rise is seen after E2.
//     valid is high during the cycle after E3.
//   Counters (registered, widths CNT_W, no wrap):
//     per_cnt: on rise <=1, else <=per_cnt+1, saturates at TIMEOUT.
//     hi_cnt: on rise <=1, else +1 while s2=1, saturates at TIMEOUT.
//     hi_hold: latches hi_cnt on fall.
//   FSM states IDLE, HIGH, LOW:
//     IDLE -> HIGH on rise: counters start, nothing published (first edge is reference).
//     HIGH -> LOW on fall: hi_hold<=hi_cnt.
//     LOW  -> HIGH on rise: period_count<=per_cnt, high_count<=hi_hold, valid<=1, timeout<=0.
//     HIGH/LOW -> IDLE when per_cnt==TIMEOUT and no rise this cycle:
//       timeout<=1, period_count<=0, high_count<=0.
//   timeout stays 1 until the next published pair or enable=0/reset.
//   valid is high exactly one cycle per publish, never in consecutive cycles.
//   Pulses shorter than 1 cycle after sync may be missed; no glitch filtering.
//   Rise and timeout in the same cycle: rise wins, so the pair publishes and timeout stays 0.
//   0% or 100% duty (line stuck): no rises, so timeout after TIMEOUT cycles.
//   enable=0: next state IDLE, per_cnt/hi_cnt/hi_hold<=0, valid=0, timeout<=0.
//     period_count/high_count hold. Sync flops keep running.
//   Re-enable: waits for a fresh rise in IDLE; first full period publishes.
//   p_reset mid-measurement: all state returns to reset values on that edge.
// TESTING
//   1 Drive PWM period 35000, high 17500 -> first valid after 2nd rise.
//     Then valid every 35000 cycles with period=35000, high=17500.
//   2 Period 100, high 1 (single-cycle pulse) -> period_count=100, high_count=1.
//   3 Hold pwm_in=1 after two good periods -> timeout=1 exactly 70000 cycles after last rise.
//     Counts read 0 -> resume PWM -> timeout clears with the second rise's valid.
//   4 enable=0 mid-high-phase for 50 cycles, then 1.
//     -> No valid during the disabled window and next partial period.
//     -> First valid is after two new rises, with correct values.
//   5 Assert p_reset 10 cycles into LOW phase -> all outputs 0 the next cycle.
//     Measurement restarts from IDLE.
//   6 Rises 3 cycles apart, TIMEOUT=3 -> valid with period_count=3 and timeout stays 0.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Measurement result bus of the PWM capture block.
interface pwm_capture_if #(
    parameter int CNT_W = 31
);
    // valid is a one-cycle strobe with no ready/backpressure: the consumer must take
    // period_count/high_count in the cycle valid is high; they hold until the next
    // publish, a timeout (forced to 0) or reset.
    logic [CNT_W-1:0] period_count;
    logic [CNT_W-1:0] high_count;
    logic             valid;
    logic             timeout;
    logic [1:0]       state;

    modport master (output period_count, high_count, valid, timeout, state);
    modport slave  (input  period_count, high_count, valid, timeout, state);
endinterface

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM line in m_clock cycles,
// publishing one coherent {period, high} pair per PWM period and flagging a stalled line.
module pwm_capture #(
    parameter int CNT_W   = 31,
    parameter int TIMEOUT = 70000
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic          enable,
    input  logic          pwm_in,
    pwm_capture_if.master meas
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             rise, fall, at_limit;
    logic             publish, expire;
    logic [CNT_W-1:0] per_cnt, hi_cnt, hi_hold;
    logic [CNT_W-1:0] period_count, high_count;
    logic             valid, timeout;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign at_limit = (per_cnt == LIMIT);

    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        expire    = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (rise) state_nxt = HIGH;
                HIGH: begin
                    if (at_limit && !rise) begin
                        state_nxt = IDLE;
                        expire    = 1'b1;
                    end else if (fall) begin
                        state_nxt = LOW;
                    end
                end
                LOW: begin
                    // A rise on the saturating cycle still publishes: rise wins over timeout.
                    if (rise) begin
                        state_nxt = HIGH;
                        publish   = 1'b1;
                    end else if (at_limit) begin
                        state_nxt = IDLE;
                        expire    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            per_cnt      <= '0;
            hi_cnt       <= '0;
            hi_hold      <= '0;
            period_count <= '0;
            high_count   <= '0;
            valid        <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1    <= pwm_in;
            s2    <= s1;
            s3    <= s2;
            valid <= publish;
            if (!enable) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
                hi_hold <= '0;
                timeout <= 1'b0;
            end else begin
                if (rise)           per_cnt <= ONE;
                else if (!at_limit) per_cnt <= per_cnt + ONE;

                if (rise)                       hi_cnt <= ONE;
                else if (s2 && hi_cnt != LIMIT) hi_cnt <= hi_cnt + ONE;

                if (fall) hi_hold <= hi_cnt;

                if (publish) begin
                    period_count <= per_cnt;
                    high_count   <= hi_hold;
                    timeout      <= 1'b0;
                end else if (expire) begin
                    period_count <= '0;
                    high_count   <= '0;
                    timeout      <= 1'b1;
                end
            end
        end
    end

    assign meas.period_count = period_count;
    assign meas.high_count   = high_count;
    assign meas.valid        = valid;
    assign meas.timeout      = timeout;
    assign meas.state        = state;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: scaled-down periods on one instance, a TIMEOUT=3 instance
// for the rise-versus-timeout boundary.
module tb_pwm_capture;
    localparam int CNT_W  = 31;
    localparam int TMO    = 700;
    localparam int CNT6_W = 8;
    localparam int TMO6   = 3;
    localparam int PW     = 2 * CNT_W;
    localparam int PW6    = 2 * CNT6_W;

    logic clk     = 1'b0;
    logic p_reset = 1'b1;
    logic enable  = 1'b1;
    logic pwm_in  = 1'b0;
    logic pwm6    = 1'b0;

    int tests_run      = 0;
    int tests_failed   = 0;
    int cyc            = 0;
    int last_valid_cyc = 0;
    int prev_valid_cyc = 0;
    logic prev_valid   = 1'b0;
    logic prev_valid6  = 1'b0;
    logic t6_window    = 1'b0;
    logic t6_seen_tmo  = 1'b0;

    logic [PW-1:0]  exp_q[$];
    logic [PW6-1:0] exp6_q[$];
    logic [PW-1:0]  pair_m;
    logic [PW6-1:0] pair_6;

    pwm_capture_if #(.CNT_W(CNT_W))  bus ();
    pwm_capture_if #(.CNT_W(CNT6_W)) bus6 ();

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .m_clock (clk),
        .p_reset (p_reset),
        .enable  (enable),
        .pwm_in  (pwm_in),
        .meas    (bus)
    );

    pwm_capture #(.CNT_W(CNT6_W), .TIMEOUT(TMO6)) dut6 (
        .m_clock (clk),
        .p_reset (p_reset),
        .enable  (enable),
        .pwm_in  (pwm6),
        .meas    (bus6)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pwm_span(input int period, input int high, input int c_from, input int c_to);
        for (int c = c_from; c < c_to; c++) begin
            @(posedge clk);
            #1 pwm_in = (c < high);
        end
    endtask

    task automatic pwm_cycles(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) pwm_span(period, high, 0, period);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 p_reset = 1'b1;
        @(posedge clk);
        #1 p_reset = 1'b0;
    endtask

    task automatic expect_pair(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({CNT_W'(p), CNT_W'(h)});
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (p_reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.valid) begin
                check("valid_back_to_back", prev_valid, 0);
                check("timeout_at_valid", bus.timeout, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.valid, 0);
                end else begin
                    pair_m = exp_q.pop_front();
                    check("period", bus.period_count, pair_m[PW-1:CNT_W]);
                    check("high", bus.high_count, pair_m[CNT_W-1:0]);
                end
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
            end
            prev_valid = bus.valid;
        end
    end

    always @(negedge clk) begin
        if (p_reset) begin
            prev_valid6 = 1'b0;
        end else begin
            if (t6_window && bus6.timeout) t6_seen_tmo = 1'b1;
            if (bus6.valid) begin
                check("t6_valid_back_to_back", prev_valid6, 0);
                check("t6_timeout_at_valid", bus6.timeout, 0);
                if (exp6_q.size() == 0) begin
                    check("t6_unexpected_valid", bus6.valid, 0);
                end else begin
                    pair_6 = exp6_q.pop_front();
                    check("t6_period", bus6.period_count, pair_6[PW6-1:CNT6_W]);
                    check("t6_high", bus6.high_count, pair_6[CNT6_W-1:0]);
                end
            end
            prev_valid6 = bus6.valid;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time %0t, expected end of run earlier", $time);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        tick(3);
        p_reset = 1'b0;
        @(negedge clk);
        check("rst_period", bus.period_count, 0);
        check("rst_high", bus.high_count, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_state", bus.state, 0);
        check("rst6_valid", bus6.valid, 0);

        // 1: nominal duty, first-publish latency, steady spacing
        expect_pair(350, 175, 3);
        pwm_cycles(350, 175, 1);
        @(posedge clk);
        #1 pwm_in = 1'b1;
        @(negedge clk) check("lat_n0", bus.valid, 0);
        @(negedge clk) check("lat_n1", bus.valid, 0);
        @(negedge clk) check("lat_n2", bus.valid, 0);
        @(negedge clk) check("lat_n3", bus.valid, 1);
        pwm_span(350, 175, 4, 350);
        pwm_cycles(350, 175, 2);
        wait_drain("t1_drain");
        check("t1_spacing", last_valid_cyc - prev_valid_cyc, 350);

        // 2: single-cycle pulse
        apply_reset();
        expect_pair(100, 1, 2);
        pwm_cycles(100, 1, 3);
        wait_drain("t2_drain");
        check("t2_high_hold", bus.high_count, 1);

        // 3: stuck-high line times out, then recovers on the second rise
        apply_reset();
        expect_pair(350, 175, 2);
        pwm_cycles(350, 175, 2);
        @(posedge clk);
        #1 pwm_in = 1'b1;
        for (int i = 0; i < 3 * TMO && bus.timeout !== 1'b1; i++) @(negedge clk);
        check("t3_timeout_seen", bus.timeout, 1);
        check("t3_timeout_latency", cyc - last_valid_cyc, TMO);
        check("t3_period_zero", bus.period_count, 0);
        check("t3_high_zero", bus.high_count, 0);
        check("t3_state_idle", bus.state, 0);
        wait_drain("t3_drain_pre");
        pwm_in = 1'b0;
        tick(50);
        check("t3_tmo_hold_low", bus.timeout, 1);
        pwm_cycles(200, 60, 1);
        check("t3_tmo_hold_ref", bus.timeout, 1);
        expect_pair(200, 60, 1);
        pwm_cycles(200, 60, 1);
        wait_drain("t3_drain");
        check("t3_tmo_cleared", bus.timeout, 0);

        // 4: enable dropped mid high phase
        apply_reset();
        expect_pair(300, 150, 2);
        pwm_cycles(300, 150, 2);
        pwm_span(300, 150, 0, 20);
        enable = 1'b0;
        pwm_span(300, 150, 20, 70);
        check("t4_drain_pre", exp_q.size(), 0);
        check("t4_period_hold", bus.period_count, 300);
        check("t4_high_hold", bus.high_count, 150);
        check("t4_state_idle", bus.state, 0);
        check("t4_timeout", bus.timeout, 0);
        enable = 1'b1;
        pwm_span(300, 150, 70, 300);
        pwm_cycles(300, 150, 1);
        expect_pair(300, 150, 1);
        pwm_cycles(300, 150, 1);
        wait_drain("t4_drain");

        // 5: reset in the low phase, then a fresh measurement
        apply_reset();
        expect_pair(200, 80, 2);
        pwm_cycles(200, 80, 2);
        pwm_span(200, 80, 0, 90);
        check("t5_drain_pre", exp_q.size(), 0);
        check("t5_pre_period", bus.period_count, 200);
        p_reset = 1'b1;
        @(posedge clk);
        #1 p_reset = 1'b0;
        check("t5_period_zero", bus.period_count, 0);
        check("t5_high_zero", bus.high_count, 0);
        check("t5_valid_zero", bus.valid, 0);
        check("t5_timeout_zero", bus.timeout, 0);
        check("t5_state_idle", bus.state, 0);
        tick(100);
        pwm_cycles(200, 80, 1);
        expect_pair(200, 80, 1);
        pwm_cycles(200, 80, 1);
        wait_drain("t5_drain");

        // 6: rises exactly TIMEOUT apart on the small instance
        for (int i = 0; i < 4; i++) exp6_q.push_back({CNT6_W'(3), CNT6_W'(1)});
        t6_window = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #1 pwm6 = (c == 0);
            end
        end
        t6_window = 1'b0;
        for (int i = 0; i < 20 && exp6_q.size() != 0; i++) @(negedge clk);
        check("t6_drain", exp6_q.size(), 0);
        check("t6_no_timeout", t6_seen_tmo, 0);
        check("t6_period_hold", bus6.period_count, 3);
        for (int i = 0; i < 20 && bus6.timeout !== 1'b1; i++) @(negedge clk);
        check("t6_timeout_after_stop", bus6.timeout, 1);
        check("t6_period_zero", bus6.period_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
